// File: rtl/mem_responder.sv
// Backing-memory responder: byte-masked beat writes, fixed-latency four-beat wrapping read bursts.
// Optional pseudo-random request backpressure is built when MEM_RESPONDER_STALL_EN is defined.
module mem_responder #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int DEPTH_BITS    = 10,
    parameter int LATENCY       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic                       mem_req_rw,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    // state      | meaning
    // IDLE       | accepting writes (every cycle) and reads
    // READ_WAIT  | read accepted, latency down-counter running
    // READ_BURST | launching one of four wrapping beats per cycle
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        READ_BURST = 2'd2
    } state_t;

    localparam int         MASK_BITS = MEM_DATA_BITS / 8;
    localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);

    logic [MEM_DATA_BITS-1:0] mem [2**DEPTH_BITS];

    state_t                state_q, state_d;
    logic [3:0]            lat_q, lat_d;
    logic [1:0]            beat_q, beat_d;
    logic [DEPTH_BITS-1:0] base_q, base_d;
    logic [1:0]            beat_row;
    logic [DEPTH_BITS-1:0] burst_row;
    logic                  stall;
    logic                  launch;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

`ifdef MEM_RESPONDER_STALL_EN
    logic [7:0] lfsr;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 8'h01;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign rd_accept = mem_req_ready && mem_req_valid && !mem_req_rw;
    assign wr_accept = mem_req_ready && mem_req_valid && mem_req_rw && mem_req_data_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    base_d  = mem_req_addr[DEPTH_BITS-1:0];
                    lat_d   = LAT_LOAD;
                    beat_d  = 2'd0;
                    state_d = (LATENCY > 1) ? READ_WAIT : READ_BURST;
                end
            end
            READ_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) state_d = READ_BURST;
            end
            READ_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_ready = 1'b0;
        launch        = 1'b0;
        case (state_q)
            IDLE:       mem_req_ready = !reset && !stall;
            READ_BURST: launch        = 1'b1;
            default:    ;
        endcase
    end

    assign mem_req_data_ready = mem_req_ready;

    // Critical beat first, wrapping inside the aligned group of four rows
    assign beat_row  = base_q[1:0] + beat_q;
    assign burst_row = {base_q[DEPTH_BITS-1:2], beat_row};

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i])
                    mem[mem_req_addr[DEPTH_BITS-1:0]][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
        end else begin
            mem_resp_valid <= launch;
            if (launch) mem_resp_data <= mem[burst_row];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=1, one at LATENCY=4,
// sharing request fields with a per-instance valid.
module tb_mem_responder;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid;
    logic          use4;
    logic [AW-1:0] req_addr;
    logic          req_rw;
    logic          data_valid;
    logic [DW-1:0] data_bits;
    logic [MW-1:0] data_mask;

    logic          v1, rdy1, drdy1, rv1;
    logic [DW-1:0] rd1;
    logic          v4, rdy4, drdy4, rv4;
    logic [DW-1:0] rd4;

    logic [DW-1:0] dv [4];
    logic [DW-1:0] r4v, r5v, r6v, r7v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign v1 = req_valid & ~use4;
    assign v4 = req_valid & use4;

    mem_responder #(.LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(v1), .mem_req_ready(rdy1), .mem_req_addr(req_addr), .mem_req_rw(req_rw),
        .mem_req_data_valid(data_valid), .mem_req_data_ready(drdy1),
        .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
        .mem_resp_valid(rv1), .mem_resp_data(rd1)
    );

    mem_responder #(.LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .mem_req_valid(v4), .mem_req_ready(rdy4), .mem_req_addr(req_addr), .mem_req_rw(req_rw),
        .mem_req_data_valid(data_valid), .mem_req_data_ready(drdy4),
        .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
        .mem_resp_valid(rv4), .mem_resp_data(rd4)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic write_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_valid = 1'b1; req_rw = 1'b1; data_valid = 1'b1;
        req_addr = a; data_bits = d; data_mask = m;
        @(negedge clk);
        check("wr_ready", use4 ? rdy4 : rdy1, 1);
        check("wr_data_ready", use4 ? drdy4 : drdy1, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; data_valid = 1'b0;
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
        @(negedge clk);
        check("rd_ready", rdy1, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_gap_valid", rv1, 0);
        check("rd_busy_ready", rdy1, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("beat%0d_valid", k), rv1, 1);
            check($sformatf("beat%0d_data", k), rd1, e[k]);
            check($sformatf("beat%0d_ready", k), rdy1, (k == 3) ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("rd_after_valid", rv1, 0);
        check("rd_after_ready", rdy1, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic          ev;
        logic [DW-1:0] ed;
        for (int k = 0; k < 4; k++)
            dv[k] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A0 + DW'(k);
        r4v = {16{8'h44}};
        r5v = {16{8'hFF}};
        r6v = {16{8'h66}};
        r7v = {16{8'h77}};

        req_valid = 1'b0; use4 = 1'b0; req_addr = '0; req_rw = 1'b0;
        data_valid = 1'b0; data_bits = '0; data_mask = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy1, 0);
        check("rst_data_ready", drdy1, 0);
        check("rst_resp_valid", rv1, 0);
        check("rst_resp_data", rd1, 0);
        check("rst_ready4", rdy4, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", rdy1, 1);
        check("post_rst_ready4", rdy4, 1);
        @(posedge clk); #1;

        // Back-to-back writes, then a read of the written group
        for (int k = 0; k < 4; k++) write_beat(AW'(32'h40 + k), dv[k], 16'hFFFF);
        read_burst(28'h40, dv[0], dv[1], dv[2], dv[3]);

        // Wrapping bursts; upper address bits are ignored
        read_burst(28'h42, dv[2], dv[3], dv[0], dv[1]);
        read_burst(28'hABC_D043, dv[3], dv[0], dv[1], dv[2]);

        // Byte masks and a write beat without data_valid
        write_beat(28'h4, r4v, 16'hFFFF);
        write_beat(28'h5, r5v, 16'hFFFF);
        write_beat(28'h6, r6v, 16'hFFFF);
        write_beat(28'h7, r7v, 16'hFFFF);
        write_beat(28'h5, '0, 16'h000F);
        write_beat(28'h7, '0, 16'h8000);
        req_valid = 1'b1; req_rw = 1'b1; data_valid = 1'b0; req_addr = 28'h6; data_bits = '0; data_mask = 16'hFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        read_burst(28'h5, {{12{8'hFF}}, 32'h0}, r6v, {8'h00, {15{8'h77}}}, r4v);

        // Reset during beat 1 aborts the burst without touching storage
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_beat1_data", rd1, dv[1]);
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", rv1, 0);
        check("midrst_data", rd1, 0);
        check("midrst_ready", rdy1, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_after_ready", rdy1, 1);
        check("midrst_after_valid", rv1, 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_no_beat", rv1, 0);
        @(posedge clk); #1;
        read_burst(28'h40, dv[0], dv[1], dv[2], dv[3]);

        // LATENCY=4 instance: read at edge T, second read held from T+1 and accepted at T+8
        use4 = 1'b1;
        for (int k = 0; k < 4; k++) write_beat(AW'(32'h40 + k), dv[k], 16'hFFFF);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h41;
        @(negedge clk);
        check("lat4_ready", rdy4, 1);
        @(posedge clk); #1;
        req_addr = 28'h42;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ev = ((c >= 4) && (c <= 7)) || ((c >= 12) && (c <= 15));
            check($sformatf("lat4_valid_c%0d", c), rv4, ev);
            check($sformatf("lat4_ready_c%0d", c), rdy4, ((c == 7) || (c == 15)) ? 1 : 0);
            if (ev) begin
                ed = (c <= 7) ? dv[(c - 3) % 4] : dv[(c - 10) % 4];
                check($sformatf("lat4_data_c%0d", c), rd4, ed);
            end
            @(posedge clk); #1;
            if (c == 7) req_valid = 1'b0;
        end
        @(negedge clk);
        check("lat4_end_valid", rv4, 0);
        check("lat4_end_data_hold", rd4, dv[1]);
        use4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
